// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared state encoding and limits for the sequential multiplier
package seq_mult_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;
  localparam int MAX_WIDTH = 32;
endpackage

// File: rtl/add_ripple.sv
// add_ripple: N-bit ripple-carry adder built from fulladder cells, carry-in 0
// ports: a, b addends; s N-bit sum; co carry-out (sum bit N)
module add_ripple #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] s,
  output logic         co
);
  logic [N:0] c;
  assign c[0] = 1'b0;
  for (genvar g = 0; g < N; g++) begin : g_fa
    fulladder u_fa (.a(a[g]), .b(b[g]), .ci(c[g]), .s(s[g]), .co(c[g+1]));
  end
  assign co = c[N];
endmodule

// File: rtl/fulladder.sv
// fulladder: one-bit full adder cell
// ports: a, b, ci addends and carry-in; s sum; co carry-out
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/seq_mult.sv
// seq_mult: sequential shift-add multiplier, WIDTH iterations, signed/unsigned
// ports: in_valid/in_ready accept a, b, is_signed; out_valid/out_ready hand off
//        the 2*WIDTH-bit product y; busy is high while CALC or DONE
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               busy
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_e             state_q;
  logic [WIDTH-1:0]   mcand_q, mplier_q, acc_q;
  logic               neg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] y_q;
  logic [WIDTH-1:0]   a_mag, b_mag, addend, sum_lo;
  logic               sum_co;
  logic [2*WIDTH-1:0] prod, y_d;
  assign a_mag  = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (is_signed && b[WIDTH-1]) ? -b : b;
  assign addend = mplier_q[0] ? mcand_q : '0;
  add_ripple #(.N(WIDTH)) u_add (.a(acc_q), .b(addend), .s(sum_lo), .co(sum_co));
  // product after this step: shifted {carry, sum} above the remaining multiplier bits
  assign prod = {sum_co, sum_lo, mplier_q[WIDTH-1:1]};
  // a zero product is never negated
  assign y_d  = (neg_q && prod != '0) ? -prod : prod;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      y_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          mcand_q  <= a_mag;
          mplier_q <= b_mag;
          neg_q    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_q    <= '0;
          cnt_q    <= '0;
          state_q  <= CALC;
        end
        CALC: begin
          acc_q    <= {sum_co, sum_lo[WIDTH-1:1]};
          mplier_q <= {sum_lo[0], mplier_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            y_q     <= y_d;
            state_q <= DONE;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;
endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: randomized self-checking bench for seq_mult at WIDTH=8 and WIDTH=3
module tb_seq_mult;
  logic clk = 1'b0, rst = 1'b1;
  logic iv8 = 1'b0, or8 = 1'b1, s8 = 1'b0, ir8, ov8, bz8;
  logic [7:0] a8 = '0, b8 = '0;
  logic [15:0] y8;
  logic iv3 = 1'b0, or3 = 1'b1, s3 = 1'b0, ir3, ov3, bz3;
  logic [2:0] a3 = '0, b3 = '0;
  logic [5:0] y3;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .y(y8), .busy(bz8)
  );
  seq_mult #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3),
    .is_signed(s3), .out_valid(ov3), .out_ready(or3), .y(y3), .busy(bz3)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s, input int w);
    longint av, bv, p;
    av = (s && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
    bv = (s && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
    p  = av * bv;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction
  task automatic mult8(input logic [7:0] a, input logic [7:0] b, input logic s, input int hold);
    int lat;
    logic [63:0] e;
    e = model({24'd0, a}, {24'd0, b}, s, 8);
    check("in_ready_idle", ir8, 1);
    a8 = a; b8 = b; s8 = s; iv8 = 1'b1; or8 = (hold == 0);
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
    check("busy_calc", bz8, 1);
    check("in_ready_calc", ir8, 0);
    lat = 0;
    while (!ov8 && lat < 20) begin
      if (lat == 3) begin iv8 = 1'b1; a8 = 8'd7; b8 = 8'd9; end else iv8 = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    iv8 = 1'b0;
    check("latency", lat, 8);
    check("y", y8, e);
    for (int i = 0; i < hold; i++) begin
      iv8 = 1'b1; a8 = 8'd7; b8 = 8'd9;
      @(posedge clk); #1;
      check("hold_ov", ov8, 1);
      check("hold_y", y8, e);
    end
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    check("ov_fall", ov8, 0);
    check("in_ready_back", ir8, 1);
    check("y_kept", y8, e);
  endtask
  task automatic mult3(input logic [2:0] a, input logic [2:0] b, input logic s);
    int lat;
    a3 = a; b3 = b; s3 = s; iv3 = 1'b1; or3 = 1'b1;
    @(posedge clk); #1;
    iv3 = 1'b0; lat = 0;
    while (!ov3 && lat < 10) begin @(posedge clk); #1; lat++; end
    check("w3_lat", lat, 3);
    check("w3_y", y3, model({29'd0, a}, {29'd0, b}, s, 3));
    @(posedge clk); #1;
  endtask
  initial begin
    logic [63:0] q[$];
    int last, nres, seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ov", ov8, 0);
    check("rst_in_ready", ir8, 1);
    check("rst_busy", bz8, 0);
    check("rst_y", y8, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    mult8(8'd255, 8'd255, 1'b0, 0);
    check("fe01_const", y8, 16'hFE01);
    mult8(8'hFD, 8'd5, 1'b1, 0);
    check("neg15_const", y8, 16'hFFF1);
    mult8(8'h80, 8'h80, 1'b1, 0);
    check("min_sq_const", y8, 16'h4000);
    mult8(8'h80, 8'h00, 1'b1, 0);
    check("min_zero_const", y8, 16'h0000);
    mult8(8'd200, 8'd3, 1'b0, 5);
    mult8(8'd7, 8'd9, 1'b0, 0);
    check("after_bp_const", y8, 16'd63);
    for (int i = 0; i < 24; i++)
      mult8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    iv8 = 1'b1; a8 = 8'd200; b8 = 8'd100; s8 = 1'b0;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_ov", ov8, 0);
    check("midrst_in_ready", ir8, 1);
    check("midrst_busy", bz8, 0);
    check("midrst_y", y8, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (ov8) seen++;
      @(posedge clk); #1;
    end
    check("midrst_no_ov", seen, 0);
    mult8(8'd12, 8'd12, 1'b0, 0);
    check("after_rst_const", y8, 16'd144);
    iv8 = 1'b1; or8 = 1'b1; last = -1; nres = 0;
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
    for (int c = 0; c < 60; c++) begin
      if (ov8) begin
        nres++;
        if (q.size() == 0) check("b2b_extra", 1, 0);
        else check("b2b_y", y8, q.pop_front());
      end
      if (ir8) begin
        if (last >= 0) check("b2b_gap", c - last, 10);
        last = c;
        q.push_back(model({24'd0, a8}, {24'd0, b8}, s8, 8));
      end
      @(posedge clk); #1;
      a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
    end
    iv8 = 1'b0;
    check("b2b_count", nres, 6);
    check("b2b_drained", q.size(), 0);
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 8; x++)
        for (int z = 0; z < 8; z++)
          mult3(3'(x), 3'(z), 1'(s));
    mult3(3'd7, 3'd7, 1'b0);
    check("w3_49", y3, 6'd49);
    mult3(3'b100, 3'b100, 1'b1);
    check("w3_16", y3, 6'd16);
    mult3(3'd3, 3'b111, 1'b1);
    check("w3_3d", y3, 6'h3D);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
